// File: rtl/operand_fetch_stage.sv
// Decode-to-execute operand fetch: forwarding select, load-use bubble insertion, execute-side registers.
// Define OPERAND_FETCH_PERF_EN to build the bubble/forward performance counters.
module operand_fetch_stage #(
  parameter int unsigned LOAD_LATENCY  = 1,
  parameter int unsigned COUNTER_WIDTH = 32
) (
  input  logic                     cpuClock,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     validIn,
  input  logic [4:0]               readAddrA,
  input  logic [4:0]               readAddrB,
  input  logic                     useImmB,
  input  logic [31:0]              immediateIn,
  input  logic [4:0]               destAddrIn,
  input  logic                     destWeIn,
  input  logic [31:0]              dataA,
  input  logic [31:0]              dataB,
  input  logic                     exWriteEnable,
  input  logic [4:0]               exWriteAddr,
  input  logic                     exIsLoad,
  input  logic [31:0]              exResult,
  input  logic                     wbWriteEnable,
  input  logic [4:0]               wbWriteAddr,
  input  logic [31:0]              wbWriteData,
  output logic [31:0]              operandA,
  output logic [31:0]              operandB,
  output logic [4:0]               destAddrOut,
  output logic                     destWeOut,
  output logic                     validOut,
  output logic                     hazardStall,
  output logic [COUNTER_WIDTH-1:0] bubbleCount,
  output logic [COUNTER_WIDTH-1:0] forwardCount
);

  typedef enum logic {RUN, BUBBLE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] operand_a_q, operand_a_d;
  logic [31:0] operand_b_q, operand_b_d;
  logic [4:0]  dest_addr_q, dest_addr_d;
  logic        dest_we_q, dest_we_d;
  logic        valid_q, valid_d;

  logic        ex_hit_a, wb_hit_a, ex_hit_b, wb_hit_b;
  logic [31:0] sel_a, sel_b;
  logic        hz;

  // A load in execute cannot forward; its consumer is caught by hz instead.
  assign ex_hit_a = (readAddrA != 5'd0) && exWriteEnable && !exIsLoad && (exWriteAddr == readAddrA);
  assign wb_hit_a = (readAddrA != 5'd0) && !ex_hit_a && wbWriteEnable && (wbWriteAddr == readAddrA);
  assign ex_hit_b = !useImmB && (readAddrB != 5'd0) && exWriteEnable && !exIsLoad
                    && (exWriteAddr == readAddrB);
  assign wb_hit_b = !useImmB && (readAddrB != 5'd0) && !ex_hit_b && wbWriteEnable
                    && (wbWriteAddr == readAddrB);

  assign sel_a = (readAddrA == 5'd0) ? 32'd0 :
                 ex_hit_a            ? exResult :
                 wb_hit_a            ? wbWriteData : dataA;
  assign sel_b = useImmB             ? immediateIn :
                 (readAddrB == 5'd0) ? 32'd0 :
                 ex_hit_b            ? exResult :
                 wb_hit_b            ? wbWriteData : dataB;

  assign hz = (state_q == RUN) && validIn && exWriteEnable && exIsLoad && (exWriteAddr != 5'd0)
              && ((exWriteAddr == readAddrA) || (!useImmB && (exWriteAddr == readAddrB)));

  assign hazardStall = hz || (state_q == BUBBLE);

  always_comb begin
    // NOTE: every _d starts as its _q so no path through this block can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    operand_a_d = operand_a_q;
    operand_b_d = operand_b_q;
    dest_addr_d = dest_addr_q;
    dest_we_d   = dest_we_q;
    valid_d     = valid_q;
    if (flush) begin
      state_d   = RUN;
      cnt_d     = 3'd0;
      valid_d   = 1'b0;
      dest_we_d = 1'b0;
    end else if (!stall) begin
      unique case (state_q)
        RUN: begin
          if (hz) begin
            state_d   = BUBBLE;
            cnt_d     = 3'(LOAD_LATENCY - 1);
            valid_d   = 1'b0;
            dest_we_d = 1'b0;
          end else begin
            operand_a_d = sel_a;
            operand_b_d = sel_b;
            dest_addr_d = destAddrIn;
            valid_d     = validIn;
            dest_we_d   = validIn && destWeIn;
          end
        end
        BUBBLE: begin
          valid_d   = 1'b0;
          dest_we_d = 1'b0;
          if (cnt_q == 3'd0) state_d = RUN;
          else               cnt_d   = cnt_q - 3'd1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge cpuClock) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
    if (reset) begin
      state_q     <= RUN;
      cnt_q       <= 3'd0;
      operand_a_q <= 32'd0;
      operand_b_q <= 32'd0;
      dest_addr_q <= 5'd0;
      dest_we_q   <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      operand_a_q <= operand_a_d;
      operand_b_q <= operand_b_d;
      dest_addr_q <= dest_addr_d;
      dest_we_q   <= dest_we_d;
      valid_q     <= valid_d;
    end
  end

  assign operandA    = operand_a_q;
  assign operandB    = operand_b_q;
  assign destAddrOut = dest_addr_q;
  assign destWeOut   = dest_we_q;
  assign validOut    = valid_q;

`ifdef OPERAND_FETCH_PERF_EN
  logic [COUNTER_WIDTH-1:0] bubble_count_q, bubble_count_d;
  logic [COUNTER_WIDTH-1:0] forward_count_q, forward_count_d;
  logic                     capture;
  logic [1:0]               fwd_sum;

  assign capture = !flush && !stall && (state_q == RUN) && !hz && validIn;
  assign fwd_sum = {1'b0, ex_hit_a || wb_hit_a} + {1'b0, ex_hit_b || wb_hit_b};

  always_comb begin
    bubble_count_d  = bubble_count_q;
    forward_count_d = forward_count_q;
    if (!flush && !stall && hazardStall) bubble_count_d = bubble_count_q + COUNTER_WIDTH'(1);
    if (capture) forward_count_d = forward_count_q + COUNTER_WIDTH'(fwd_sum);
  end

  always_ff @(posedge cpuClock) begin
    if (reset) begin
      bubble_count_q  <= '0;
      forward_count_q <= '0;
    end else begin
      bubble_count_q  <= bubble_count_d;
      forward_count_q <= forward_count_d;
    end
  end

  assign bubbleCount  = bubble_count_q;
  assign forwardCount = forward_count_q;
`else
  assign bubbleCount  = '0;
  assign forwardCount = '0;
`endif

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed literal cases, then random traffic against a
// cycle-level reference model compared on every falling edge.
module tb_operand_fetch_stage;
  localparam int unsigned LL = 2;
`ifdef OPERAND_FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        cpuClock = 1'b0;
  logic        reset, stall, flush, validIn, useImmB, destWeIn;
  logic [4:0]  readAddrA, readAddrB, destAddrIn, exWriteAddr, wbWriteAddr;
  logic [31:0] immediateIn, dataA, dataB, exResult, wbWriteData;
  logic        exWriteEnable, exIsLoad, wbWriteEnable;
  logic [31:0] operandA, operandB, bubbleCount, forwardCount;
  logic [4:0]  destAddrOut;
  logic        destWeOut, validOut, hazardStall;

  always #5 cpuClock = ~cpuClock;

  operand_fetch_stage #(.LOAD_LATENCY(LL), .COUNTER_WIDTH(32)) dut (
    .cpuClock(cpuClock), .reset(reset), .stall(stall), .flush(flush), .validIn(validIn),
    .readAddrA(readAddrA), .readAddrB(readAddrB), .useImmB(useImmB), .immediateIn(immediateIn),
    .destAddrIn(destAddrIn), .destWeIn(destWeIn), .dataA(dataA), .dataB(dataB),
    .exWriteEnable(exWriteEnable), .exWriteAddr(exWriteAddr), .exIsLoad(exIsLoad),
    .exResult(exResult), .wbWriteEnable(wbWriteEnable), .wbWriteAddr(wbWriteAddr),
    .wbWriteData(wbWriteData), .operandA(operandA), .operandB(operandB),
    .destAddrOut(destAddrOut), .destWeOut(destWeOut), .validOut(validOut),
    .hazardStall(hazardStall), .bubbleCount(bubbleCount), .forwardCount(forwardCount)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: registered outputs plus the number of bubble cycles still owed.
  logic [31:0] m_a, m_b, m_bc, m_fc;
  logic [4:0]  m_dest;
  logic        m_we, m_valid;
  int          m_bub;
  bit          cmp_en = 1'b0;

  function automatic bit ex_fwd(input logic [4:0] idx);
    return idx != 0 && exWriteEnable && !exIsLoad && exWriteAddr == idx;
  endfunction

  function automatic bit wb_fwd(input logic [4:0] idx);
    return idx != 0 && !ex_fwd(idx) && wbWriteEnable && wbWriteAddr == idx;
  endfunction

  function automatic logic [31:0] pick(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 0)    return 32'd0;
    if (ex_fwd(idx)) return exResult;
    if (wb_fwd(idx)) return wbWriteData;
    return rf;
  endfunction

  function automatic bit model_hz();
    return m_bub == 0 && validIn && exWriteEnable && exIsLoad && exWriteAddr != 0 &&
           (exWriteAddr == readAddrA || (!useImmB && exWriteAddr == readAddrB));
  endfunction

  function automatic bit model_hs();
    return m_bub > 0 || model_hz();
  endfunction

  always @(posedge cpuClock) begin
    bit hz;
    hz = model_hz();
    if (reset) begin
      m_a = 0; m_b = 0; m_dest = 0; m_we = 0; m_valid = 0; m_bub = 0; m_bc = 0; m_fc = 0;
    end else if (flush) begin
      m_valid = 0; m_we = 0; m_bub = 0;
    end else if (!stall) begin
      if (m_bub > 0 || hz) m_bc = m_bc + 1;
      if (m_bub > 0) begin
        m_bub--; m_valid = 0; m_we = 0;
      end else if (hz) begin
        m_bub = LL; m_valid = 0; m_we = 0;
      end else begin
        m_a     = pick(readAddrA, dataA);
        m_b     = useImmB ? immediateIn : pick(readAddrB, dataB);
        m_dest  = destAddrIn;
        m_valid = validIn;
        m_we    = validIn && destWeIn;
        if (validIn)
          m_fc = m_fc + 32'(ex_fwd(readAddrA) || wb_fwd(readAddrA))
                      + 32'(!useImmB && (ex_fwd(readAddrB) || wb_fwd(readAddrB)));
      end
    end
  end

  always @(negedge cpuClock) begin
    if (cmp_en) begin
      check("operandA",     {32'd0, operandA},     {32'd0, m_a});
      check("operandB",     {32'd0, operandB},     {32'd0, m_b});
      check("destAddrOut",  {59'd0, destAddrOut},  {59'd0, m_dest});
      check("destWeOut",    {63'd0, destWeOut},    {63'd0, m_we});
      check("validOut",     {63'd0, validOut},     {63'd0, m_valid});
      check("hazardStall",  {63'd0, hazardStall},  {63'd0, model_hs()});
      check("bubbleCount",  {32'd0, bubbleCount},  PERF ? {32'd0, m_bc} : 64'd0);
      check("forwardCount", {32'd0, forwardCount}, PERF ? {32'd0, m_fc} : 64'd0);
    end
  end

  task automatic step();
    @(posedge cpuClock);
    #1;
  endtask

  task automatic set_idle();
    stall = 0; flush = 0; validIn = 0; useImmB = 0; destWeIn = 0;
    readAddrA = 0; readAddrB = 0; destAddrIn = 0; immediateIn = 0; dataA = 0; dataB = 0;
    exWriteEnable = 0; exWriteAddr = 0; exIsLoad = 0; exResult = 0;
    wbWriteEnable = 0; wbWriteAddr = 0; wbWriteData = 0;
  endtask

  task automatic randomize_inputs(input bit hold);
    if (!hold) begin
      validIn     = ($urandom_range(0, 3) != 0);
      readAddrA   = 5'($urandom_range(0, 3));
      readAddrB   = 5'($urandom_range(0, 3));
      useImmB     = ($urandom_range(0, 3) == 0);
      immediateIn = $urandom;
      destAddrIn  = 5'($urandom_range(0, 31));
      destWeIn    = 1'($urandom);
    end
    dataA         = $urandom;
    dataB         = $urandom;
    exWriteEnable = 1'($urandom);
    exWriteAddr   = 5'($urandom_range(0, 3));
    exIsLoad      = ($urandom_range(0, 2) == 0);
    exResult      = $urandom;
    wbWriteEnable = 1'($urandom);
    wbWriteAddr   = 5'($urandom_range(0, 3));
    wbWriteData   = $urandom;
    stall         = ($urandom_range(0, 9) == 0);
    flush         = ($urandom_range(0, 19) == 0);
    reset         = ($urandom_range(0, 149) == 0);
  endtask

  initial begin
    bit hold;
    set_idle();
    reset = 1;
    step();
    cmp_en = 1'b1;
    step();
    check("reset_operandA", {32'd0, operandA}, 64'd0);
    check("reset_validOut", {63'd0, validOut}, 64'd0);
    check("reset_destWeOut", {63'd0, destWeOut}, 64'd0);
    reset = 0;

    // No hazard: plain register file read.
    validIn = 1; readAddrA = 3; readAddrB = 4; dataA = 32'h11; dataB = 32'h22;
    destAddrIn = 9; destWeIn = 1;
    step();
    check("t1_operandA", {32'd0, operandA}, 64'h11);
    check("t1_operandB", {32'd0, operandB}, 64'h22);
    check("t1_validOut", {63'd0, validOut}, 64'd1);
    check("t1_destAddr", {59'd0, destAddrOut}, 64'd9);

    // EX and WB both target r5: EX wins.
    readAddrA = 5; readAddrB = 6; dataB = 32'h33;
    exWriteEnable = 1; exWriteAddr = 5; exResult = 32'hDEAD;
    wbWriteEnable = 1; wbWriteAddr = 5; wbWriteData = 32'hBEEF;
    step();
    check("t2_operandA", {32'd0, operandA}, 64'hDEAD);
    check("t2_operandB", {32'd0, operandB}, 64'h33);
    check("t2_fwdcount", {32'd0, forwardCount}, PERF ? 64'd1 : 64'd0);

    // Load-use on B with LL=2: three stall cycles, then the WB value is captured.
    readAddrA = 1; readAddrB = 7; dataA = 32'h1; wbWriteEnable = 0;
    exWriteEnable = 1; exWriteAddr = 7; exIsLoad = 1;
    #1 check("t3_hz0", {63'd0, hazardStall}, 64'd1);
    step();
    exWriteEnable = 0; exIsLoad = 0;
    #1 check("t3_hz1", {63'd0, hazardStall}, 64'd1);
    check("t3_v1", {63'd0, validOut}, 64'd0);
    step();
    check("t3_hz2", {63'd0, hazardStall}, 64'd1);
    check("t3_v2", {63'd0, validOut}, 64'd0);
    wbWriteEnable = 1; wbWriteAddr = 7; wbWriteData = 32'h77;
    step();
    check("t3_hz3", {63'd0, hazardStall}, 64'd0);
    check("t3_v3", {63'd0, validOut}, 64'd0);
    step();
    check("t3_v4", {63'd0, validOut}, 64'd1);
    check("t3_operandB", {32'd0, operandB}, 64'h77);
    check("t3_bubcount", {32'd0, bubbleCount}, PERF ? 64'd3 : 64'd0);

    // r0 never forwards and a load into r0 is not a hazard.
    readAddrA = 0; readAddrB = 2; dataA = 32'h1234; dataB = 32'h44;
    exWriteEnable = 1; exWriteAddr = 0; exResult = 32'hFFFF; exIsLoad = 0;
    wbWriteEnable = 1; wbWriteAddr = 0; wbWriteData = 32'hFFFF;
    step();
    check("t4_operandA", {32'd0, operandA}, 64'd0);
    check("t4_operandB", {32'd0, operandB}, 64'h44);
    exIsLoad = 1;
    #1 check("t4_nohz", {63'd0, hazardStall}, 64'd0);
    step();
    check("t4_valid", {63'd0, validOut}, 64'd1);

    // Flush in the first bubble cycle returns to RUN.
    readAddrA = 3; exWriteAddr = 3; exIsLoad = 1; wbWriteEnable = 0;
    step();
    flush = 1; exWriteEnable = 0; exIsLoad = 0;
    #1 check("t5_hz_bubble", {63'd0, hazardStall}, 64'd1);
    step();
    flush = 0; dataA = 32'h55;
    #1 check("t5_hz_after", {63'd0, hazardStall}, 64'd0);
    check("t5_valid_after", {63'd0, validOut}, 64'd0);
    step();
    check("t5_capture", {32'd0, operandA}, 64'h55);

    // Stall freezes everything; reset beats stall.
    stall = 1; dataA = 32'h99; validIn = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_frozenA", {32'd0, operandA}, 64'h55);
      check("t6_frozenV", {63'd0, validOut}, 64'd1);
    end
    reset = 1;
    step();
    check("t6_rstA", {32'd0, operandA}, 64'd0);
    check("t6_rstB", {32'd0, operandB}, 64'd0);
    check("t6_rstV", {63'd0, validOut}, 64'd0);
    reset = 0; stall = 0;

    // Random traffic; decode holds while the stage asks it to (or the pipe is stalled).
    hold = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      randomize_inputs(hold);
      @(negedge cpuClock);
      hold = (model_hs() || stall) && !flush && !reset;
      @(posedge cpuClock);
      #1;
    end

    @(negedge cpuClock);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
